// File: rtl/ls245_arb_pkg.sv
// Shared types and constants for the LS245 two-requester bus arbiter.
// Optional round-robin tie-break is selected with ARB_ROUND_ROBIN_EN.
package ls245_arb_pkg;

    localparam int unsigned NREQ = 2;

    localparam logic DIR_A2B = 1'b1;
    localparam logic DIR_B2A = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StTurn,
        StOwn
    } arb_state_e;

endpackage

// File: rtl/ls245_arb_pick.sv
// Combinational winner select for the LS245 bus arbiter.
// ARB_ROUND_ROBIN_EN: ties go to the requester not served last; otherwise requester 0 wins.
module ls245_arb_pick
    import ls245_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last_served,
    output logic            valid,
    output logic            winner
);

    always_comb begin
        valid = |req;
`ifdef ARB_ROUND_ROBIN_EN
        if (req[0] && req[1]) begin
            winner = ~last_served;
        end else begin
            winner = ~req[0];
        end
`else
        winner = ~req[0];
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

endmodule

// File: rtl/ls245_bus_arbiter.sv
// Arbiter/sequencer driving OE and DIR of two LS245 transceivers sharing one bus.
// ARB_ROUND_ROBIN_EN selects round-robin tie-break in ls245_arb_pick.
module ls245_bus_arbiter
    import ls245_arb_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 1,
    parameter int unsigned HOLD_MAX    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] we,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] oe,
    output logic [NREQ-1:0] dir,
    output logic            timeout
);

    localparam int unsigned HoldW = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HoldW-1:0] HoldLim = HoldW'(HOLD_MAX);

    // TURN exits on the edge where the counter is zero, so the load value sets the
    // number of all-off cycles. From IDLE one extra cycle is spent; a direction change
    // needs at least two so DIR can move on an edge with OE low on both sides.
    localparam logic [2:0] DeadIdle = 3'(DEAD_CYCLES);
    localparam logic [2:0] DeadPre  = 3'(DEAD_CYCLES - 1);
    localparam logic [2:0] DeadDir  = (DEAD_CYCLES > 1) ? 3'(DEAD_CYCLES - 1) : 3'd1;

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic [2:0]       dead_q, dead_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             last_served_q, last_served_d;
    logic [NREQ-1:0]  dir_q, dir_d;
    logic [NREQ-1:0]  oe_q, oe_d;
    logic             timeout_q, timeout_d;
    logic             other;
    logic             pick_valid;
    logic             pick_winner;

    ls245_arb_pick u_pick (
        .req         (req),
        .last_served (last_served_q),
        .valid       (pick_valid),
        .winner      (pick_winner)
    );

    assign other = ~owner_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        dead_d        = dead_q;
        hold_d        = hold_q;
        last_served_d = last_served_q;
        dir_d         = dir_q;
        timeout_d     = 1'b0;
        oe_d          = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d              = pick_winner;
                    dir_d[pick_winner]   = we[pick_winner];
                    dead_d               = DeadIdle;
                    state_d              = StTurn;
                end
            end
            StTurn: begin
                if (!req[owner_q]) begin
                    state_d = StIdle;
                end else if (dead_q == 3'd0) begin
                    state_d       = StOwn;
                    hold_d        = HoldW'(1);
                    last_served_d = owner_q;
                end else begin
                    // OE is low before and after this edge, so DIR may follow WE here.
                    dead_d         = dead_q - 3'd1;
                    dir_d[owner_q] = we[owner_q];
                end
            end
            StOwn: begin
                if (hold_q != HoldLim) begin
                    hold_d = hold_q + HoldW'(1);
                end
                if (!req[owner_q]) begin
                    state_d = StIdle;
                end else if ((HOLD_MAX != 0) && (hold_q == HoldLim) && req[other]) begin
                    timeout_d    = 1'b1;
                    owner_d      = other;
                    dir_d[other] = we[other];
                    dead_d       = DeadPre;
                    state_d      = StTurn;
                end else if (we[owner_q] != dir_q[owner_q]) begin
                    dead_d  = DeadDir;
                    state_d = StTurn;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StOwn) begin
            oe_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            owner_q       <= 1'b0;
            dead_q        <= 3'd0;
            hold_q        <= '0;
            last_served_q <= 1'b1;
            dir_q         <= {NREQ{DIR_B2A}};
            oe_q          <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            dead_q        <= dead_d;
            hold_q        <= hold_d;
            last_served_q <= last_served_d;
            dir_q         <= dir_d;
            oe_q          <= oe_d;
            timeout_q     <= timeout_d;
        end
    end

    assign gnt     = oe_q;
    assign oe      = oe_q;
    assign dir     = dir_q;
    assign timeout = timeout_q;

endmodule
